// File: rtl/mat_vec_mult.sv
// 8-row matrix-vector multiply: row/vector FIFOs feed a skewed systolic chain of MACs.
// Optional MAT_VEC_MULT_OUT_REG_EN: registered outputs loaded when done rises.
module mat_vec_mult #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                Clr,
  input  logic                                a_wren,
  input  logic [7:0][DATA_WIDTH-1:0]          a_fifo_in,
  input  logic                                b_wren,
  input  logic [DATA_WIDTH-1:0]               b_fifo_in,
  output logic [7:0][3*DATA_WIDTH-1:0]        out,
  output logic                                done,
  output logic [1:0]                          state_dbg
);

  localparam int ROWS = 8;
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int RW   = 3 * DATA_WIDTH;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int TW   = $clog2(ROWS + DEPTH);
  localparam int LAST = ROWS + DEPTH - 2;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_next;
  logic [TW-1:0] step;

  logic [DATA_WIDTH-1:0] a_mem [ROWS][DEPTH];
  logic [DATA_WIDTH-1:0] b_mem [DEPTH];
  logic [AW-1:0]         a_wr_ptr;
  logic [AW-1:0]         a_rd_ptr [ROWS];
  logic [AW-1:0]         b_wr_ptr;
  logic [AW-1:0]         b_rd_ptr;
  logic [CW-1:0]         a_level [ROWS];
  logic [CW-1:0]         b_level;

  logic                  a_push, b_push, a_full, b_full;

  logic                  mac_valid [ROWS];
  logic [DATA_WIDTH-1:0] mac_a     [ROWS];
  logic [DATA_WIDTH-1:0] mac_b     [ROWS];
  logic [PW-1:0]         prod      [ROWS];
  logic [RW-1:0]         acc       [ROWS];
  logic [RW-1:0]         acc_next  [ROWS];
  // Stage registers carrying b and its valid from MAC i to MAC i+1.
  logic                  v_pipe    [ROWS-1];
  logic [DATA_WIDTH-1:0] b_pipe    [ROWS-1];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    a_full = 1'b1;
    for (int i = 0; i < ROWS; i++) begin
      if (a_level[i] != CW'(DEPTH)) a_full = 1'b0;
    end
    b_full = (b_level == CW'(DEPTH));
    a_push = a_wren && (state == LOAD) && (a_level[0] != CW'(DEPTH));
    b_push = b_wren && (state == LOAD) && !b_full;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (a_full && b_full) state_next = COMPUTE;
      COMPUTE: if (step == TW'(LAST)) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = LOAD;
    endcase
  end

  // MAC 0 takes b from the FIFO head; MAC i>0 takes it one stage later.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      if (i == 0) begin
        mac_valid[i] = (state == COMPUTE) && (step < TW'(DEPTH));
        mac_b[i]     = b_mem[b_rd_ptr];
      end else begin
        mac_valid[i] = v_pipe[i-1];
        mac_b[i]     = b_pipe[i-1];
      end
      mac_a[i]    = a_mem[i][a_rd_ptr[i]];
      prod[i]     = PW'(mac_a[i]) * PW'(mac_b[i]);
      acc_next[i] = mac_valid[i] ? acc[i] + RW'(prod[i]) : acc[i];
    end
  end

  always_ff @(posedge clk) begin
    if (a_push) begin
      for (int i = 0; i < ROWS; i++) a_mem[i][a_wr_ptr] <= a_fifo_in[i];
    end
    if (b_push) b_mem[b_wr_ptr] <= b_fifo_in;
  end

  always_ff @(posedge clk) begin
    if (rst || Clr) begin
      state    <= LOAD;
      step     <= '0;
      a_wr_ptr <= '0;
      b_wr_ptr <= '0;
      b_rd_ptr <= '0;
      b_level  <= '0;
      for (int i = 0; i < ROWS; i++) begin
        a_rd_ptr[i] <= '0;
        a_level[i]  <= '0;
        acc[i]      <= '0;
      end
      for (int i = 0; i < ROWS - 1; i++) begin
        v_pipe[i] <= 1'b0;
        b_pipe[i] <= '0;
      end
    end else begin
      state <= state_next;
      step  <= (state == COMPUTE) ? step + TW'(1) : '0;

      if (a_push) a_wr_ptr <= ptr_inc(a_wr_ptr);
      if (b_push) begin
        b_wr_ptr <= ptr_inc(b_wr_ptr);
        b_level  <= b_level + CW'(1);
      end else if (mac_valid[0]) begin
        b_rd_ptr <= ptr_inc(b_rd_ptr);
        b_level  <= b_level - CW'(1);
      end

      for (int i = 0; i < ROWS; i++) begin
        if (a_push) begin
          a_level[i] <= a_level[i] + CW'(1);
        end else if (mac_valid[i]) begin
          a_rd_ptr[i] <= ptr_inc(a_rd_ptr[i]);
          a_level[i]  <= a_level[i] - CW'(1);
        end
        acc[i] <= acc_next[i];
      end

      for (int i = 0; i < ROWS - 1; i++) begin
        v_pipe[i] <= mac_valid[i];
        b_pipe[i] <= mac_b[i];
      end
    end
  end

`ifdef MAT_VEC_MULT_OUT_REG_EN
  logic [RW-1:0] out_reg [ROWS];

  // Captured from acc_next so the final products land on the same edge as done.
  always_ff @(posedge clk) begin
    if (rst || Clr) begin
      for (int i = 0; i < ROWS; i++) out_reg[i] <= '0;
    end else if ((state == COMPUTE) && (state_next == DONE)) begin
      for (int i = 0; i < ROWS; i++) out_reg[i] <= acc_next[i];
    end
  end

  always_comb begin
    for (int i = 0; i < ROWS; i++) out[i] = out_reg[i];
  end
`else
  always_comb begin
    for (int i = 0; i < ROWS; i++) out[i] = acc[i];
  end
`endif

  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mat_vec_mult.sv
// Self-checking bench for mat_vec_mult: scoreboard of expected row results.
module tb_mat_vec_mult;

  localparam int DW = 8;
  localparam int RW = 3 * DW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 Clr;
  logic                 a_wren;
  logic [7:0][DW-1:0]   a_fifo_in;
  logic                 b_wren;
  logic [DW-1:0]        b_fifo_in;
  logic [7:0][RW-1:0]   out;
  logic                 done;
  logic [1:0]           state_dbg;

  mat_vec_mult #(.DEPTH(8), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .Clr       (Clr),
    .a_wren    (a_wren),
    .a_fifo_in (a_fifo_in),
    .b_wren    (b_wren),
    .b_fifo_in (b_fifo_in),
    .out       (out),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [RW-1:0] exp_q[$];
  logic [DW-1:0] a_m [8][8];
  logic [DW-1:0] b_v [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference model: plain dot products, or zeros for an aborted run.
  task automatic push_expected(input bit aborted);
    int sum;
    for (int i = 0; i < 8; i++) begin
      sum = 0;
      for (int k = 0; k < 8; k++) sum += int'(a_m[i][k]) * int'(b_v[k]);
      exp_q.push_back(aborted ? '0 : RW'(sum));
    end
  endtask

  task automatic load_parallel();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a_wren = 1'b1;
      b_wren = 1'b1;
      for (int i = 0; i < 8; i++) a_fifo_in[i] = a_m[i][k];
      b_fifo_in = b_v[k];
    end
    @(posedge clk);
    #1;
    a_wren = 1'b0;
    b_wren = 1'b0;
  endtask

  task automatic load_b_first();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b_wren    = 1'b1;
      b_fifo_in = b_v[k];
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b_wren = 1'b0;
      a_wren = 1'b1;
      for (int i = 0; i < 8; i++) a_fifo_in[i] = a_m[i][k];
    end
    @(posedge clk);
    #1;
    a_wren = 1'b0;
  endtask

  // Counts edges after load completion until done; mode 1 adds stray writes, mode 2 a Clr pulse.
  task automatic wait_done(input int mode, output int edges);
    edges = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (mode == 1) begin
        case (n)
          1: begin a_wren = 1'b1; for (int i = 0; i < 8; i++) a_fifo_in[i] = 8'hFF; end
          2: a_wren = 1'b0;
          3: begin b_wren = 1'b1; b_fifo_in = 8'hFF; end
          4: b_wren = 1'b0;
          6: begin a_wren = 1'b1; b_wren = 1'b1; end
          7: begin a_wren = 1'b0; b_wren = 1'b0; end
          default: ;
        endcase
      end else if (mode == 2) begin
        if (n == 5) Clr = 1'b1;
        if (n == 6) Clr = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done && edges == 0) edges = n;
    end
  endtask

  task automatic check_results(input string name);
    logic [RW-1:0] e;
    for (int i = 0; i < 8; i++) begin
      if (exp_q.size() == 0) begin
        check($sformatf("%s_q_empty", name), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_out%0d", name, i), 32'(out[i]), 32'(e));
      end
    end
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    Clr = 1'b1;
    @(negedge clk);
    Clr = 1'b0;
  endtask

  task automatic run_case(input string name, input int mode, input bit b_first);
    int edges;
    push_expected(mode == 2);
    if (b_first) load_b_first();
    else         load_parallel();
    wait_done(mode, edges);
    if (mode == 2) begin
      check({name, "_no_done"}, 32'(edges), 32'd0);
      check({name, "_done_low"}, 32'(done), 32'd0);
      check({name, "_state_load"}, 32'(state_dbg), 32'd0);
    end else begin
      check({name, "_done_edge"}, 32'(edges), 32'd16);
      check({name, "_done_sticky"}, 32'(done), 32'd1);
      check({name, "_state_done"}, 32'(state_dbg), 32'd2);
    end
    check_results(name);
    clear_pulse();
  endtask

  initial begin
    logic [DW-1:0] col [8];
    col = '{8'd5, 8'd2, 8'd3, 8'd1, 8'd7, 8'd4, 8'd2, 8'd2};

    // Reset with writes asserted: they must be ignored.
    rst       = 1'b1;
    Clr       = 1'b0;
    a_wren    = 1'b1;
    b_wren    = 1'b1;
    a_fifo_in = '{default: 8'd9};
    b_fifo_in = 8'd9;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) check($sformatf("reset_out%0d", i), 32'(out[i]), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    rst    = 1'b0;
    a_wren = 1'b0;
    b_wren = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_state", 32'(state_dbg), 32'd0);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) a_m[i][k] = col[k];
      b_v[k] = DW'(k + 1);
    end
    run_case("uniform", 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) a_m[i][k] = 8'hFF;
      b_v[k] = 8'hFF;
    end
    run_case("max", 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) a_m[i][k] = DW'(i + 1);
      b_v[k] = 8'd1;
    end
    run_case("rows", 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) a_m[i][k] = DW'($urandom_range(0, 255));
      b_v[k] = DW'($urandom_range(0, 255));
    end
    run_case("overflow", 1, 1'b1);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) a_m[i][k] = DW'($urandom_range(0, 255));
      b_v[k] = DW'($urandom_range(0, 255));
    end
    run_case("clr_abort", 2, 1'b0);
    run_case("after_clr", 0, 1'b0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
